// File: rtl/sub_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_share_pkg
// Description : Shared types, defaults and subtract helper for sub_share_arb.
//               SUB_SHARE_ARB_SAT_EN selects the saturating subtract.
// Revision    : 1.0  initial release
// ============================================================================
package sub_share_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;

    // Operands are zero-extended to this width; DATA_W must not exceed it.
    localparam int c_CALC_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Returns {borrow, diff}; the caller keeps the low DATA_W bits of diff.
    function automatic logic [c_CALC_W:0] sub_calc(
        input logic [c_CALC_W-1:0] x,
        input logic [c_CALC_W-1:0] y
    );
        logic                borrow;
        logic [c_CALC_W-1:0] diff;
        borrow = (x < y);
`ifdef SUB_SHARE_ARB_SAT_EN
        diff   = borrow ? '0 : (x - y);
`else
        diff   = x - y;
`endif
        return {borrow, diff};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : sub_rr_pick
// Description : Combinational round-robin picker; searches upward from
//               rr_ptr+1, wrapping modulo NUM_REQ.
// Revision    : 1.0  initial release
// ============================================================================
module sub_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_valid
);

    localparam logic [ID_W:0] c_NUM = (ID_W+1)'(NUM_REQ);

    always_comb begin
        logic [ID_W:0] w_pos;
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        w_pos     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // rr_ptr + k stays below 2*NUM_REQ, so one subtract wraps it.
            w_pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (w_pos >= c_NUM) begin
                w_pos = w_pos - c_NUM;
            end
            if (!any_valid && req_valid[w_pos[ID_W-1:0]]) begin
                any_valid                 = 1'b1;
                grant[w_pos[ID_W-1:0]]    = 1'b1;
                grant_idx                 = w_pos[ID_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sub_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : sub_share_arb
// Description : Round-robin arbiter/sequencer sharing one subtract unit
//               between NUM_REQ requesters. Define SUB_SHARE_ARB_SAT_EN for
//               an unsigned saturating result.
// Revision    : 1.0  initial release
// ============================================================================
module sub_share_arb
    import sub_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_x,
    input  logic [NUM_REQ*DATA_W-1:0] req_y,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_diff,
    output logic                      rsp_borrow,
    input  logic                      rsp_ready,
    output logic                      busy
);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ID_W-1:0]      r_rr_ptr;
    logic [ID_W-1:0]      r_id;
    logic [DATA_W-1:0]    r_x;
    logic [DATA_W-1:0]    r_y;

    logic                 r_rsp_valid;
    logic [ID_W-1:0]      r_rsp_id;
    logic [DATA_W-1:0]    r_rsp_diff;
    logic                 r_rsp_borrow;

    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_grant_idx;
    logic                 w_any_valid;
    logic                 w_xfer;
    logic                 w_rsp_fire;
    logic [c_CALC_W:0]    w_calc;

    logic [DATA_W-1:0]    w_x_arr [NUM_REQ];
    logic [DATA_W-1:0]    w_y_arr [NUM_REQ];

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_x_arr[g] = req_x[g*DATA_W +: DATA_W];
            assign w_y_arr[g] = req_y[g*DATA_W +: DATA_W];
        end
    endgenerate

    sub_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .ID_W      (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any_valid (w_any_valid)
    );

    // The picker only grants valid requesters, so a grant in IDLE is a transfer.
    assign w_xfer     = (r_state == IDLE) && w_any_valid;
    assign w_rsp_fire = (r_state == RESP) && r_rsp_valid && rsp_ready;

    assign w_calc = sub_calc(c_CALC_W'(r_x), c_CALC_W'(r_y));

    generate
        if (DATA_W < c_CALC_W) begin : g_calc_pad
            logic w_calc_unused;
            assign w_calc_unused = ^w_calc[c_CALC_W-1:DATA_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_xfer)     w_state_nxt = EXEC;
            EXEC:                    w_state_nxt = RESP;
            RESP:    if (w_rsp_fire) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // Grant is masked while reset is held so req_ready reads as zero then.
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if ((r_state == IDLE) && rst_n) begin
            req_ready = w_grant;
        end
        if ((r_state == EXEC) || (r_state == RESP)) begin
            busy = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= ID_W'(NUM_REQ - 1);
            r_id         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_diff   <= '0;
            r_rsp_borrow <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_x  <= w_x_arr[w_grant_idx];
                r_y  <= w_y_arr[w_grant_idx];
                r_id <= w_grant_idx;
            end
            if (r_state == EXEC) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_id     <= r_id;
                r_rsp_diff   <= w_calc[DATA_W-1:0];
                r_rsp_borrow <= w_calc[c_CALC_W];
            end
            if (w_rsp_fire) begin
                r_rsp_valid <= 1'b0;
                r_rr_ptr    <= r_id;
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_diff   = r_rsp_diff;
    assign rsp_borrow = r_rsp_borrow;

endmodule
`default_nettype wire

// File: tb/tb_sub_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_share_arb
// Description : Self-checking bench for sub_share_arb (directed vectors plus a
//               cycle-level reference model). Honours SUB_SHARE_ARB_SAT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sub_share_arb;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic [NR-1:0]    req_valid  = '0;
    logic [NR*DW-1:0] req_x      = '0;
    logic [NR*DW-1:0] req_y      = '0;
    logic [NR-1:0]    req_ready;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [DW-1:0]    rsp_diff;
    logic             rsp_borrow;
    logic             rsp_ready  = 1'b0;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub_share_arb #(
        .NUM_REQ    (NR),
        .DATA_W     (DW),
        .ID_W       (IW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_diff   (rsp_diff),
        .rsp_borrow (rsp_borrow),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_diff(input int x, input int y);
`ifdef SUB_SHARE_ARB_SAT_EN
        return (x < y) ? 0 : x - y;
`else
        return (x - y + 256) % 256;
`endif
    endfunction

    // Reference model: one operation in flight, result visible from the
    // second cycle after the transfer until it is accepted.
    bit m_busy = 0, m_vld = 0, m_brw = 0;
    int m_age = 0, m_op = 0, m_last = NR - 1, m_x = 0, m_y = 0, m_id = 0, m_diff = 0;

    function automatic int pick();
        for (int k = 1; k <= NR; k++) begin
            if (req_valid[(m_last + k) % NR] === 1'b1) return (m_last + k) % NR;
        end
        return -1;
    endfunction

    always @(negedge rst_n) begin
        m_busy = 0; m_vld = 0; m_brw = 0; m_age = 0;
        m_id = 0; m_diff = 0; m_last = NR - 1;
    end

    always @(negedge clk) begin
        int p;
        logic [NR-1:0] er;
        p  = pick();
        er = '0;
        if (rst_n && !m_busy && p >= 0) er = NR'(1 << p);
        chk("m_req_ready", 32'(req_ready), 32'(er));
        chk("m_busy", 32'(busy), 32'(m_busy));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(m_vld));
        chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
        chk("m_rsp_diff", 32'(rsp_diff), 32'(m_diff));
        chk("m_rsp_borrow", 32'(rsp_borrow), 32'(m_brw));
        if (rst_n) begin
            if (!m_busy) begin
                if (p >= 0) begin
                    m_busy = 1; m_age = 0; m_op = p;
                    m_x = int'(req_x[p*DW +: DW]);
                    m_y = int'(req_y[p*DW +: DW]);
                end
            end else if (m_age == 0) begin
                m_age = 1; m_vld = 1; m_id = m_op;
                m_brw = (m_x < m_y); m_diff = exp_diff(m_x, m_y);
            end else if (rsp_ready === 1'b1) begin
                m_busy = 0; m_vld = 0; m_last = m_op;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int x, input int y);
        req_x[i*DW +: DW] = 8'(x);
        req_y[i*DW +: DW] = 8'(y);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Directed single operation on requester i, result checked two cycles later.
    task automatic one_op(input string nm, input int i, input int x, input int y,
                          input int ed, input int eb);
        set_op(i, x, y);
        req_valid = NR'(1 << i);
        #1 chk({nm, "_ready"}, 32'(req_ready), 32'(1 << i));
        tick();
        req_valid = '0;
        tick();
        #1;
        chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, "_id"}, 32'(rsp_id), 32'(i));
        chk({nm, "_diff"}, 32'(rsp_diff), 32'(ed));
        chk({nm, "_borrow"}, 32'(rsp_borrow), 32'(eb));
        tick();
    endtask

    int g_idx[8];
    int g_cyc[8];
    int ng;
    int tbl_diff[4] = '{60, 63, 66, 69};
    int exp_ord[5]  = '{0, 1, 2, 3, 0};
    bit saw;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1 chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        rsp_ready = 1'b1;

        one_op("single", 0, 100, 30, 70, 0);
`ifdef SUB_SHARE_ARB_SAT_EN
        one_op("borrow", 2, 5, 10, 0, 1);
`else
        one_op("borrow", 2, 5, 10, 251, 1);
`endif

        // All requesters valid from reset: 0,1,2,3,0 every 3 cycles.
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, 60 + 10 * i, 7 * i);
        req_valid = '1;
        ng = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (req_ready != '0 && ng < 8) begin
                for (int i = 0; i < NR; i++) if (req_ready[i]) g_idx[ng] = i;
                g_cyc[ng] = c;
                ng++;
            end
            if (rsp_valid) chk("rr_diff", 32'(rsp_diff), 32'(tbl_diff[rsp_id]));
            if (c == 13) req_valid = '0;
            tick();
        end
        chk("rr_count", 32'(ng), 32'd5);
        for (int j = 0; j < 5; j++) begin
            if (j < ng) begin
                chk("rr_order", 32'(g_idx[j]), 32'(exp_ord[j]));
                chk("rr_cycle", 32'(g_cyc[j]), 32'(3 * j));
            end
        end
        tick();
        tick();

        // Backpressure on requester 1 while requester 3 waits.
        do_reset();
        rsp_ready = 1'b0;
        set_op(1, 200, 1);
        set_op(3, 40, 50);
        req_valid = 4'b1010;
        #1 chk("bp_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1000;
        tick();
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_diff", 32'(rsp_diff), 32'd199);
            chk("bp_borrow", 32'(rsp_borrow), 32'd0);
            chk("bp_noready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("bp_hold", 32'(rsp_valid), 32'd1);
        tick();
        #1 chk("bp_next", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        tick();
        #1;
        chk("bp3_id", 32'(rsp_id), 32'd3);
        chk("bp3_diff", 32'(rsp_diff), 32'(exp_diff(40, 50)));
        chk("bp3_borrow", 32'(rsp_borrow), 32'd1);
        tick();

        // Reset while EXEC: output clears at once and no response follows.
        set_op(0, 9, 3);
        req_valid = 4'b0001;
        #1 chk("rx_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rx_valid", 32'(rsp_valid), 32'd0);
        chk("rx_busy", 32'(busy), 32'd0);
        chk("rx_diff", 32'(rsp_diff), 32'd0);
        chk("rx_borrow", 32'(rsp_borrow), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("rx_quiet", 32'(rsp_valid), 32'd0);
            tick();
        end
        one_op("rx_again", 0, 9, 3, 6, 0);

        one_op("ff_ff", 0, 255, 255, 0, 0);
`ifdef SUB_SHARE_ARB_SAT_EN
        one_op("zero_ff", 0, 0, 255, 0, 1);
`else
        one_op("zero_ff", 0, 0, 255, 1, 1);
`endif

        // Requester 1 withdraws before it can be granted.
        set_op(0, 1, 1);
        req_valid = 4'b0001;
        tick();
        set_op(1, 50, 5);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        saw = 0;
        for (int i = 0; i < 8; i++) begin
            #1 if (rsp_valid && rsp_id == 2'd1) saw = 1;
            tick();
        end
        chk("drop_no_id1", 32'(saw), 32'd0);
        chk("drop_idle", 32'(busy), 32'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
